// File: rtl/conv1_window_ctrl.sv
// conv1_window_ctrl: sequences a raster pixel stream into a line buffer
// (2*IMG_W+3 deep) and flags when the buffer output holds a full 3x3 window.
// Optional build macro: CONV1_STRIDE2_EN -- only windows whose top-left
// coordinate is even in both axes are flagged, and coordinates are halved.
//
// Handshake: a pixel is transferred on a rising edge where pix_valid and
// pix_ready are both high; pix_ready depends only on state and fifo_full,
// never on pix_valid, and pix_data must be stable while pix_valid is high.
module conv1_window_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 224,
  parameter int IMG_H      = 224,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic                  fifo_rst,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  win_valid,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            win_valid_q, win_valid_d;
  logic [RW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;

  logic            accept;
  logic            last_col;
  logic            last_pix;
  logic            fill_last;
  logic [RW-1:0]   row_m2;
  logic [CW-1:0]   col_m2;
  logic            win_hit;

  // The empty flag carries no sequencing meaning here.
  logic unused_fifo_empty;
  assign unused_fifo_empty = fifo_empty;

  // Handshake and line-buffer strobes; everything is held off during reset.
  assign pix_ready    = rst && ((state_q == S_FILL && !fifo_full) || state_q == S_STREAM);
  assign accept       = pix_valid && pix_ready;
  assign fifo_wr_en   = accept;
  assign fifo_rd_en   = accept && (state_q == S_STREAM);
  assign fifo_rst     = !rst || (state_q == S_CLR);
  assign fifo_data_in = pix_data;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);
  assign dbg_state    = state_q;
  assign win_valid    = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;

  // Position decodes of the pixel currently offered.
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_pix  = last_col && (row_q == RW'(IMG_H - 1));
  // Pixel (2,2) is the (2*IMG_W+3)th of the frame: the buffer is then primed.
  assign fill_last = (row_q == RW'(2)) && (col_q == CW'(2));
  assign row_m2    = row_q - RW'(2);
  assign col_m2    = col_q - CW'(2);

  // Next state of the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLR;
      S_CLR:    state_d = S_FILL;
      S_FILL: begin
        if (accept && last_pix)       state_d = S_DONE;
        else if (accept && fill_last) state_d = S_STREAM;
      end
      S_STREAM: if (accept && last_pix) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Raster position counters, advanced only by accepted pixels.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == S_CLR) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window flag for the pixel accepted this cycle, presented next cycle.
  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
`ifdef CONV1_STRIDE2_EN
    win_hit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_m2[0] && !col_m2[0];
    if (win_hit) begin
      win_row_d = row_m2 >> 1;
      win_col_d = col_m2 >> 1;
    end
`else
    win_hit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    if (win_hit) begin
      win_row_d = row_m2;
      win_col_d = col_m2;
    end
`endif
    win_valid_d = win_hit;
  end

  // State, counter and window registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

endmodule

// File: tb/tb_conv1_window_ctrl.sv
// tb_conv1_window_ctrl: 6x6 frames driven with random and directed handshake
// patterns, compared every cycle against a pixel-count reference model.
module tb_conv1_window_ctrl;

  localparam int DW = 16;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int FILL_N = 2 * W + 3;
`ifdef CONV1_STRIDE2_EN
  localparam int EXP_WIN = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int EXP_WIN = (W - 2) * (H - 2);
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          fifo_full = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          pix_ready, fifo_wr_en, fifo_rd_en, fifo_rst;
  logic [DW-1:0] fifo_data_in;
  logic          win_valid, busy, frame_done;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  conv1_window_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_rd_en(fifo_rd_en), .fifo_rst(fifo_rst), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame progress is tracked as a count of accepted pixels; position is
  // derived arithmetically from that count.
  bit m_clr, m_active, m_done;
  int n_acc;
  bit m_wv;
  int m_wr, m_wc;
  int win_seen;
  bit chk_en = 1'b0;
  bit e_ready, e_acc;
  int cyc = 0;

  task automatic model_step();
    int r, c;
    bit hit;
    if (!rst) begin
      m_clr = 0; m_active = 0; m_done = 0; n_acc = 0;
      m_wv = 0; m_wr = 0; m_wc = 0;
      exp_q.delete();
    end else begin
      hit = 0;
      if (e_acc) begin
        r = n_acc / W;
        c = n_acc % W;
`ifdef CONV1_STRIDE2_EN
        hit = (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
        if (hit) begin m_wr = (r - 2) / 2; m_wc = (c - 2) / 2; end
`else
        hit = (r >= 2) && (c >= 2);
        if (hit) begin m_wr = r - 2; m_wc = c - 2; end
`endif
        if (hit) exp_q.push_back({8'(m_wr), 8'(m_wc)});
      end
      m_wv = hit;
      if (m_done) m_done = 0;
      else if (m_clr) begin m_clr = 0; m_active = 1; n_acc = 0; win_seen = 0; end
      else if (m_active) begin
        if (e_acc) begin
          n_acc++;
          if (n_acc == W * H) begin m_active = 0; m_done = 1; end
        end
      end else if (start) m_clr = 1;
    end
  endtask

  // ---------------- driver ----------------
  // One clock: apply inputs, compare at the falling edge, advance the model.
  task automatic cycle(input bit r, input bit s, input bit v, input bit full);
    logic [15:0] e;
    bit fill;
    rst = r; start = s; pix_valid = v; fifo_full = full;
    pix_data = DW'($urandom);
    fifo_empty = DW'($urandom_range(0, 1)) != 0;
    @(negedge clk);
    fill    = n_acc < FILL_N;
    e_ready = rst && m_active && (fill ? !fifo_full : 1'b1);
    e_acc   = pix_valid && e_ready;
    if (chk_en) begin
      check_eq("pix_ready",   pix_ready,    e_ready);
      check_eq("fifo_wr_en",  fifo_wr_en,   e_acc);
      check_eq("fifo_rd_en",  fifo_rd_en,   e_acc && !fill);
      check_eq("fifo_rst",    fifo_rst,     !rst || m_clr);
      check_eq("fifo_data",   fifo_data_in, pix_data);
      check_eq("busy",        busy,         m_clr || m_active || m_done);
      check_eq("frame_done",  frame_done,   m_done);
      check_eq("win_valid",   win_valid,    m_wv);
      check_eq("win_row",     win_row,      m_wr);
      check_eq("win_col",     win_col,      m_wc);
      if (win_valid === 1'b1) begin
        win_seen++;
        if (exp_q.size() == 0) check_eq("q_underflow", win_valid, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("q_row", win_row, e[15:8]);
          check_eq("q_col", win_col, e[7:0]);
        end
      end
      if (m_done) check_eq("win_count", win_seen, EXP_WIN);
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  // mode 0: continuous valid; 1: random valid/full/start;
  // 2: full held after 5 fill pixels, valid toggling in stream, start mid-stream;
  // 3: continuous valid with reset at pixel 20.
  task automatic run_frame(input int mode);
    int budget;
    int full_cnt;
    bit v, f, s, r;
    full_cnt = 0;
    cycle(1, 1, 0, 0);
    for (budget = 0; budget < 2000; budget++) begin
      if (!(m_clr || m_active || m_done)) break;
      v = 1; f = 0; s = 0; r = 1;
      case (mode)
        1: begin
          v = $urandom_range(0, 3) != 0;
          f = $urandom_range(0, 3) == 0;
          s = $urandom_range(0, 7) == 0;
        end
        2: begin
          if (m_active && n_acc >= 5 && n_acc < FILL_N && full_cnt < 8) begin
            f = 1; full_cnt++;
          end
          if (m_active && n_acc >= FILL_N) v = cyc[0];
          s = m_active && n_acc == 20;
        end
        3: r = !(m_active && n_acc == 20);
        default: ;
      endcase
      cycle(r, s, v, f);
    end
    if (m_clr || m_active || m_done) check_eq("frame_timeout", m_active, 0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    cycle(0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    run_frame(0);
    cycle(1, 0, 1, 0);
    run_frame(2);
    run_frame(1);
    run_frame(3);
    cycle(1, 0, 0, 0);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    cycle(1, 0, 0, 0);
    check_eq("q_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv1_window_ctrl.md
CONV1_WINDOW_CTRL -- requirements
Module: conv1_window_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width in bits.
REQ-002 Parameter IMG_W, default 224: pixels per image row.
REQ-003 Parameter IMG_H, default 224: rows per frame.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (0 = reset).
REQ-006 start  input  1  one-cycle pulse requesting a new frame.
REQ-007 pix_valid  input  1  source pixel valid.
REQ-008 pix_data  input  DATA_WIDTH  source pixel, raster order.
REQ-009 pix_ready  output  1  controller accepts pixel this cycle.
REQ-010 fifo_data_in  output  DATA_WIDTH  pixel to line buffer.
REQ-011 fifo_wr_en  output  1  line-buffer write strobe.
REQ-012 fifo_rd_en  output  1  line-buffer pop strobe.
REQ-013 fifo_rst  output  1  line-buffer clear, active-high.
REQ-014 fifo_full  input  1  line-buffer full flag.
REQ-015 fifo_empty  input  1  line-buffer empty flag.
REQ-016 win_valid  output  1  3x3 window on line-buffer output is valid.
REQ-017 win_row, win_col  output  clog2(IMG_H), clog2(IMG_W)  output coordinate of the valid window.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-020 FSM states IDLE, CLR, FILL, STREAM, DONE; an accepted pixel is pix_valid && pix_ready.
REQ-021 IDLE -> CLR on start; start in any other state is ignored.
REQ-022 CLR lasts exactly one cycle with fifo_rst=1, clears counters, then goes to FILL.
REQ-023 pix_ready = (FILL && !fifo_full) || STREAM, combinational; it is 0 in IDLE, CLR and DONE.
REQ-024 fifo_wr_en equals the accepted-pixel condition in the same cycle, and fifo_data_in = pix_data.
REQ-025 FILL: accepted pixels write only; after the (2*IMG_W+3)th accepted pixel, the FSM moves to STREAM.
REQ-026 STREAM: each accepted pixel asserts fifo_wr_en and fifo_rd_en in the same cycle, so occupancy stays at 2*IMG_W+3.
REQ-027 Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the accepted pixel; col wraps to 0 and row increments at IMG_W-1.
REQ-028 An accepted pixel at (row,col) with row>=2 and col>=2 sets win_valid=1 in the next cycle, with win_row=row-2 and win_col=col-2 registered; win_valid is 0 otherwise.
REQ-029 Accepting pixel (IMG_H-1, IMG_W-1) moves the FSM to DONE; DONE asserts frame_done for one cycle, then the FSM returns to IDLE.
REQ-030 In DONE, win_valid for the final pixel (REQ-028) coincides with frame_done.
REQ-031 pix_valid low stalls all counters; no strobes are issued.
REQ-032 fifo_empty is informational only; it does not alter sequencing.

Reset
REQ-033 With rst=0 at a clock edge: state=IDLE, counters=0, and win_valid, win_row, win_col, frame_done and busy are 0.
REQ-034 During reset, fifo_rst=1, while fifo_wr_en, fifo_rd_en and pix_ready are 0.
REQ-035 Reset mid-frame abandons the frame; no frame_done is issued.

Configuration
REQ-036 Macro CONV1_STRIDE2_EN defined: win_valid is asserted only when (row-2) and (col-2) are both even, with win_row=(row-2)/2 and win_col=(col-2)/2.
REQ-037 CONV1_STRIDE2_EN undefined: stride 1 per REQ-028; fill and handshake behaviour is identical in both builds.

Verification
REQ-038 IMG_W=IMG_H=6, start, continuous valid -> fifo_rst for 1 cycle, first win_valid after the 15th pixel with (0,0), 16 windows in total, frame_done 1 cycle after the 36th pixel.
REQ-039 IMG_W=6, fifo_full forced high during FILL after 5 pixels -> pix_ready=0 and no writes until fifo_full drops.
REQ-040 STREAM with pix_valid toggled every other cycle -> fifo_wr_en and fifo_rd_en pulse together only on accepted cycles, and window coordinates stay sequential.
REQ-041 rst=0 at pixel 20 of a 6x6 frame -> all outputs 0 next cycle; new start restarts with windows again at (0,0).
REQ-042 CONV1_STRIDE2_EN defined, 6x6 frame -> exactly 4 windows at (0,0),(0,1),(1,0),(1,1).
REQ-043 start pulsed during STREAM -> ignored, with no fifo_rst and no counter change.
